mul_err_monitor: RTL and testbench
==================================

Name: mul_err_monitor

Overview:
- Downstream checker for the approximate 8x8 recursive multipliers.
- Consumes operand pairs a, b and the approximate product Y. Computes the exact product a*b internally.
- Accumulates accuracy statistics in hardware over a programmed number of samples: mismatch count, sum of error distance, maximum error distance and the operands that produced it.
- Replaces exhaustive simulation-only accuracy checks with a synthesizable on-chip monitor.

Parameters:
- WIDTH, 8, operand width; products are 2*WIDTH bits.
- CNT_W, 17, sample/error counter width; the default holds 65536.
- SUM_W, 32, width of the sum-of-error-distance accumulator.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; arms a new run (honoured in IDLE and DONE only)
- num_samples  in  CNT_W  sample target N, latched on accepted start
- in_valid  in  1  sample present on a, b, y_approx
- in_ready  out  1  monitor accepts sample this cycle
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- y_approx  in  2*WIDTH  approximate product under test
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- sample_cnt  out  CNT_W  samples accumulated
- err_cnt  out  CNT_W  samples with y_approx != a*b
- sum_ed  out  SUM_W  saturating sum of |y_approx - a*b|
- max_ed  out  2*WIDTH  largest error distance seen
- max_a, max_b  out  WIDTH  operands of the first sample reaching max_ed
- sum_bias  out  SUM_W+1  signed sum of (y_approx - a*b); see Optional Feature

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, all outputs 0, pipeline valid bits cleared, latched N = 0. Reset mid-run aborts the run; no partial statistics are kept.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: clear all statistics, latch N, go RUN. start in RUN or DRAIN is ignored.
  - RUN: accept counter counts accepted samples. When the counter equals N (including N = 0 on the first RUN cycle), go DRAIN.
  - DRAIN: wait until both pipeline valid bits are 0, then go DONE.
  - DONE: statistics held stable; done = 1 until the next start.
- Handshake:
  - in_ready = 1 only in RUN with accepted < N; it is combinational from state and counter.
  - Accept = in_valid & in_ready.
  - in_ready drops in the cycle after the Nth accept.
  - in_valid with in_ready = 0 is ignored; no buffering.
- Pipeline:
  - Stage 1 registers a, b, y_approx and exact = a*b (full 2*WIDTH, unsigned).
  - Stage 2 computes ed = |y_approx - exact| and updates statistics.
  - Statistics reflect a sample 2 clocks after its accept edge.
  - Back-to-back accepts are supported at 1 sample per clock.
- Arithmetic:
  - sample_cnt += 1 per stage-2 sample.
  - err_cnt += 1 when ed != 0.
  - sum_ed saturates at all-ones and never wraps.
  - max_ed/max_a/max_b update only when ed > max_ed (strictly greater), so ties keep the first occurrence.
  - Counters do not exceed N, so no counter wrap is possible.
- DONE → start with new N: statistics cleared in the same edge that enters RUN.

Optional Feature:
- Macro ERR_BIAS_EN.
- Defined: sum_bias accumulates signed (y_approx - exact) per sample, two's complement, SUM_W+1 bits, saturating at the most-positive and most-negative values. It is cleared on start and reset.
- Undefined: sum_bias is tied to 0 and no bias logic is generated.

Test Plan:
- Exact model (y_approx = a*b), N=65536, full a/b sweep, in_valid always high → sample_cnt 65536, err_cnt 0, sum_ed 0, max_ed 0, done after 65536 + drain cycles.
- N=1, a=15, b=15, y_approx=200 → err_cnt 1, sum_ed 25, max_ed 25, max_a 15, max_b 15, sum_bias -25 (ERR_BIAS_EN).
- N=4, in_valid toggling with gaps, errors 1,3,3,0 (3s at a=5 then a=9) → sum_ed 7, max_ed 3, max_a 5, err_cnt 3; in_ready low after the 4th accept with in_valid still high.
- SUM_W=8, N=10, each sample ed 30 → sum_ed 255 (saturated), err_cnt 10.
- rst_n=0 for one cycle during RUN after 3 accepts → next cycle IDLE, all outputs 0, in_ready 0; a new start runs cleanly.
- start with N=0 → busy, then done with all statistics 0; in_ready never asserted; start pulses during RUN ignored.

Source files
------------

// File: rtl/mul_err_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_err_monitor
// Description : On-chip accuracy monitor for approximate WIDTHxWIDTH
//               multipliers (mismatches, sum/max error distance). Define
//               ERR_BIAS_EN to add the saturating signed bias accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_err_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 17,
    parameter int SUM_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   y_approx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [SUM_W-1:0]     sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     max_b,
    output logic [SUM_W:0]       sum_bias
);

    localparam int PW    = 2 * WIDTH;
    localparam int EXT_W = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam logic [EXT_W-1:0] c_SUM_MAX = {{(EXT_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, acc_q;
    logic               v1_q, v2_q;
    logic [WIDTH-1:0]   a1_q, b1_q, a2_q, b2_q;
    logic [PW-1:0]      y1_q, ex1_q, ed2_q;
    logic [CNT_W-1:0]   sample_cnt_q, err_cnt_q;
    logic [SUM_W-1:0]   sum_ed_q;
    logic [PW-1:0]      max_ed_q;
    logic [WIDTH-1:0]   max_a_q, max_b_q;

    logic               w_start_ok;
    logic               w_accept;
    logic [PW-1:0]      w_exact;
    logic [PW-1:0]      w_ed;
    logic [EXT_W-1:0]   w_sum_ext;
    logic [SUM_W-1:0]   w_sum_next;

    assign w_start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign in_ready   = (state_q == S_RUN) && (acc_q < n_q);
    assign w_accept   = in_valid && in_ready;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN:          if (acc_q == n_q) state_d = S_DRAIN;
            S_DRAIN:        if (!v1_q && !v2_q) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q   <= '0;
            acc_q <= '0;
        end else if (w_start_ok) begin
            n_q   <= num_samples;
            acc_q <= '0;
        end else if (w_accept) begin
            acc_q <= acc_q + CNT_W'(1);
        end
    end

    // Valid bits are flushed on start as well as reset so a new run never
    // sees a sample left over from an aborted one.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_ok) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= w_accept;
            v2_q <= v1_q;
        end
    end

    assign w_exact = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_ed    = (y1_q >= ex1_q) ? (y1_q - ex1_q) : (ex1_q - y1_q);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            a1_q  <= a;
            b1_q  <= b;
            y1_q  <= y_approx;
            ex1_q <= w_exact;
        end
        if (v1_q) begin
            a2_q  <= a1_q;
            b2_q  <= b1_q;
            ed2_q <= w_ed;
        end
    end

    assign w_sum_ext  = {{(EXT_W-SUM_W){1'b0}}, sum_ed_q} + {{(EXT_W-PW){1'b0}}, ed2_q};
    assign w_sum_next = (w_sum_ext > c_SUM_MAX) ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];

    // Strict greater-than keeps the operands of the first sample at the max.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_ok) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_ed_q     <= '0;
            max_ed_q     <= '0;
            max_a_q      <= '0;
            max_b_q      <= '0;
        end else if (v2_q) begin
            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            if (ed2_q != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
            sum_ed_q <= w_sum_next;
            if (ed2_q > max_ed_q) begin
                max_ed_q <= ed2_q;
                max_a_q  <= a2_q;
                max_b_q  <= b2_q;
            end
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_ed_q;
    assign max_ed     = max_ed_q;
    assign max_a      = max_a_q;
    assign max_b      = max_b_q;

`ifdef ERR_BIAS_EN
    localparam int DW = PW + 1;
    localparam int BW = (((SUM_W + 1) > DW) ? (SUM_W + 1) : DW) + 1;
    localparam logic signed [BW-1:0] c_BIAS_MAX = {{(BW-SUM_W){1'b0}}, {SUM_W{1'b1}}};
    localparam logic signed [BW-1:0] c_BIAS_MIN = {{(BW-SUM_W){1'b1}}, {SUM_W{1'b0}}};

    logic [PW:0]            diff2_q;
    logic [SUM_W:0]         bias_q;
    logic signed [BW-1:0]   w_bias_ext;

    always_ff @(posedge clk) begin
        if (v1_q) diff2_q <= {1'b0, y1_q} - {1'b0, ex1_q};
    end

    assign w_bias_ext = $signed({{(BW-SUM_W-1){bias_q[SUM_W]}}, bias_q})
                      + $signed({{(BW-DW){diff2_q[PW]}}, diff2_q});

    always_ff @(posedge clk) begin
        if (!rst_n || w_start_ok) begin
            bias_q <= '0;
        end else if (v2_q) begin
            if (w_bias_ext > c_BIAS_MAX)      bias_q <= c_BIAS_MAX[SUM_W:0];
            else if (w_bias_ext < c_BIAS_MIN) bias_q <= c_BIAS_MIN[SUM_W:0];
            else                              bias_q <= w_bias_ext[SUM_W:0];
        end
    end

    assign sum_bias = bias_q;
`else
    assign sum_bias = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_err_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mul_err_monitor
// Description : Directed self-checking bench for mul_err_monitor (default
//               instance plus an 8-bit-sum instance for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_err_monitor;

    localparam int WIDTH = 8;
    localparam int CNT_W = 17;
    localparam int SUM_W = 32;
    localparam int SUM_S = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_samples = '0;
    logic               in_valid = 1'b0;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic [2*WIDTH-1:0] y_approx = '0;

    logic               in_ready, busy, done;
    logic [CNT_W-1:0]   sample_cnt, err_cnt;
    logic [SUM_W-1:0]   sum_ed;
    logic [2*WIDTH-1:0] max_ed;
    logic [WIDTH-1:0]   max_a, max_b;
    logic [SUM_W:0]     sum_bias;

    logic               in_ready_s, busy_s, done_s;
    logic [CNT_W-1:0]   sample_cnt_s, err_cnt_s;
    logic [SUM_S-1:0]   sum_ed_s;
    logic [2*WIDTH-1:0] max_ed_s;
    logic [WIDTH-1:0]   max_a_s, max_b_s;
    logic [SUM_S:0]     sum_bias_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .y_approx(y_approx),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .sum_ed(sum_ed), .max_ed(max_ed), .max_a(max_a), .max_b(max_b),
        .sum_bias(sum_bias)
    );

    mul_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SUM_W(SUM_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .y_approx(y_approx),
        .busy(busy_s), .done(done_s), .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s),
        .sum_ed(sum_ed_s), .max_ed(max_ed_s), .max_a(max_a_s), .max_b(max_b_s),
        .sum_bias(sum_bias_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start       = 1'b0;
    endtask

    task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] yy);
        int k;
        a = aa; b = bb; y_approx = yy; in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: got in_ready=%b required 1 within 50 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: got done=%b required 1 within %0d cycles", done, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({busy, done, in_ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got busy/done/ready=%b required 000", {busy, done, in_ready});
        end
        n_checks++;
        if (sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d/%0d required 0/0/0", sample_cnt, err_cnt, sum_ed);
        end
        n_checks++;
        if (max_ed !== 0 || max_a !== 0 || max_b !== 0 || sum_bias !== 0) begin
            n_fail++; $display("FAIL reset_max: got %0d/%0d/%0d/%0d required all 0", max_ed, max_a, max_b, sum_bias);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, in_ready} !== 3'b000) begin
            n_fail++; $display("FAIL idle_ctrl: got busy/done/ready=%b required 000", {busy, done, in_ready});
        end
    endtask

    task automatic test_single();
        logic [SUM_W:0] eb;
        start_run(17'd1);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_run: got busy=%b ready=%b required 1/1", busy, in_ready);
        end
        a = 8'd15; b = 8'd15; y_approx = 16'd200; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || sample_cnt !== 0) begin
            n_fail++; $display("FAIL single_lat0: got ready=%b cnt=%0d required 0/0", in_ready, sample_cnt);
        end
        tick();
        n_checks++;
        if (sample_cnt !== 0) begin
            n_fail++; $display("FAIL single_lat1: got cnt=%0d required 0", sample_cnt);
        end
        tick();
        n_checks++;
        if (sample_cnt !== 1) begin
            n_fail++; $display("FAIL single_lat2: got cnt=%0d required 1", sample_cnt);
        end
        wait_done(10);
        n_checks++;
        if (err_cnt !== 1 || sum_ed !== 25 || max_ed !== 25 || max_a !== 15 || max_b !== 15) begin
            n_fail++; $display("FAIL single_stats: got err=%0d sum=%0d max=%0d a=%0d b=%0d required 1/25/25/15/15",
                               err_cnt, sum_ed, max_ed, max_a, max_b);
        end
`ifdef ERR_BIAS_EN
        eb = -33'sd25;
`else
        eb = '0;
`endif
        n_checks++;
        if (sum_bias !== eb) begin
            n_fail++; $display("FAIL single_bias: got %0d required %0d", $signed(sum_bias), $signed(eb));
        end
    endtask

    task automatic test_gaps();
        logic [SUM_W:0] eb;
        start_run(17'd4);
        send(8'd2, 8'd3, 16'd7);
        tick(); tick();
        send(8'd5, 8'd7, 16'd32);
        tick();
        send(8'd9, 8'd4, 16'd39);
        tick(); tick(); tick();
        a = 8'd10; b = 8'd10; y_approx = 16'd100; in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL gaps_ready4: got in_ready=%b required 1", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL gaps_ready_drop: got in_ready=%b required 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL gaps_ready_hold: got in_ready=%b required 0", in_ready);
        end
        wait_done(10);
        in_valid = 1'b0;
        n_checks++;
        if (sample_cnt !== 4 || err_cnt !== 3 || sum_ed !== 7) begin
            n_fail++; $display("FAIL gaps_cnt: got cnt=%0d err=%0d sum=%0d required 4/3/7", sample_cnt, err_cnt, sum_ed);
        end
        n_checks++;
        if (max_ed !== 3 || max_a !== 5 || max_b !== 7) begin
            n_fail++; $display("FAIL gaps_max: got max=%0d a=%0d b=%0d required 3/5/7", max_ed, max_a, max_b);
        end
`ifdef ERR_BIAS_EN
        eb = 33'd1;
`else
        eb = '0;
`endif
        n_checks++;
        if (sum_bias !== eb) begin
            n_fail++; $display("FAIL gaps_bias: got %0d required %0d", $signed(sum_bias), $signed(eb));
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        logic [SUM_W:0] eb;
        logic [SUM_S:0] ebs;
        start_run(17'd10);
        stalls = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 8'(i + 1); b = 8'd1; y_approx = 16'(i + 31);
            if (in_ready !== 1'b1) stalls++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (stalls !== 0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_flow: got stalls=%0d ready=%b required 0/0", stalls, in_ready);
        end
        wait_done(10);
        n_checks++;
        if (sample_cnt !== 10 || err_cnt !== 10 || sum_ed !== 300) begin
            n_fail++; $display("FAIL b2b_cnt: got cnt=%0d err=%0d sum=%0d required 10/10/300", sample_cnt, err_cnt, sum_ed);
        end
        n_checks++;
        if (max_ed !== 30 || max_a !== 1 || max_b !== 1) begin
            n_fail++; $display("FAIL b2b_tie: got max=%0d a=%0d b=%0d required 30/1/1", max_ed, max_a, max_b);
        end
        n_checks++;
        if (sum_ed_s !== 8'd255 || err_cnt_s !== 10) begin
            n_fail++; $display("FAIL sat_sum: got sum=%0d err=%0d required 255/10", sum_ed_s, err_cnt_s);
        end
`ifdef ERR_BIAS_EN
        eb  = 33'd300;
        ebs = 9'd255;
`else
        eb  = '0;
        ebs = '0;
`endif
        n_checks++;
        if (sum_bias !== eb || sum_bias_s !== ebs) begin
            n_fail++; $display("FAIL b2b_bias: got %0d/%0d required %0d/%0d",
                               $signed(sum_bias), $signed(sum_bias_s), $signed(eb), $signed(ebs));
        end
    endtask

    task automatic test_reset_midrun();
        start_run(17'd8);
        in_valid = 1'b1;
        a = 8'd3; b = 8'd3; y_approx = 16'd0;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({busy, done, in_ready} !== 3'b000) begin
            n_fail++; $display("FAIL abort_ctrl: got busy/done/ready=%b required 000", {busy, done, in_ready});
        end
        tick(); tick();
        n_checks++;
        if (sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0 || sum_bias !== 0) begin
            n_fail++; $display("FAIL abort_stats: got cnt=%0d err=%0d sum=%0d max=%0d required all 0",
                               sample_cnt, err_cnt, sum_ed, max_ed);
        end
        start_run(17'd2);
        send(8'd4, 8'd4, 16'd16);
        send(8'd255, 8'd255, 16'd65025);
        wait_done(10);
        n_checks++;
        if (sample_cnt !== 2 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0) begin
            n_fail++; $display("FAIL rerun_stats: got cnt=%0d err=%0d sum=%0d max=%0d required 2/0/0/0",
                               sample_cnt, err_cnt, sum_ed, max_ed);
        end
    endtask

    task automatic test_zero_n();
        int ready_seen;
        ready_seen = 0;
        in_valid = 1'b1;
        a = 8'd7; b = 8'd7; y_approx = 16'd0;
        start_run(17'd0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL zero_run: got busy=%b done=%b ready=%b required 1/0/0", busy, done, in_ready);
        end
        start = 1'b1;
        num_samples = 17'd5;
        tick();
        if (in_ready !== 1'b0) ready_seen++;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b0) ready_seen++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ready_seen !== 0) begin
            n_fail++; $display("FAIL zero_done: got done=%b busy=%b ready_cycles=%0d required 1/0/0", done, busy, ready_seen);
        end
        n_checks++;
        if (sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0 || max_a !== 0 || sum_bias !== 0) begin
            n_fail++; $display("FAIL zero_stats: got cnt=%0d err=%0d sum=%0d max=%0d required all 0",
                               sample_cnt, err_cnt, sum_ed, max_ed);
        end
    endtask

    task automatic test_exact_sweep();
        int stalls;
        int k;
        start_run(17'h10000);
        stalls = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            a = i[15:8];
            b = i[7:0];
            y_approx = {8'd0, i[15:8]} * {8'd0, i[7:0]};
            if (in_ready !== 1'b1) stalls++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (stalls !== 0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL sweep_flow: got stalls=%0d ready=%b required 0/0", stalls, in_ready);
        end
        k = 0;
        while (done !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        n_checks++;
        if (done !== 1'b1 || k > 4) begin
            n_fail++; $display("FAIL sweep_drain: got done=%b after %0d cycles required 1 within 4", done, k);
        end
        n_checks++;
        if (sample_cnt !== 17'h10000 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0) begin
            n_fail++; $display("FAIL sweep_stats: got cnt=%0d err=%0d sum=%0d max=%0d required 65536/0/0/0",
                               sample_cnt, err_cnt, sum_ed, max_ed);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gaps();
        test_back_to_back();
        test_reset_midrun();
        test_zero_n();
        test_exact_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
